// File: rtl/reg_write_buffer.sv
// Small FIFO feeding a register's wrEn/dataIn pins with registered write strobes.
// Optional sticky overflow flag enabled by defining REG_WRITE_BUFFER_OVERFLOW_EN.
module reg_write_buffer #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   input  logic [WIDTH-1:0] inData,
   output logic             inReady,
   input  logic             hold,
   output logic             wrEn,
   output logic [WIDTH-1:0] dataOut,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en_q, wr_en_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             push, pop;

   // full/empty come from the count alone, so the pointers can wrap freely
   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign inReady = !full;
   assign push    = inValid && inReady;
   assign pop     = !empty && !hold;

   assign count   = count_q;
   assign wrEn    = wr_en_q;
   assign dataOut = data_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wr_en_d  = pop;
      data_d   = data_q;
      if (push) begin
         mem_d[wr_ptr_q] = inData;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      // pop reads the old storage, so a same-edge push is never bypassed
      if (pop) begin
         data_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wr_en_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wr_en_q  <= wr_en_d;
         data_q   <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef REG_WRITE_BUFFER_OVERFLOW_EN
   logic ovf_q, ovf_d;

   assign ovf_d    = ovf_q || (inValid && full);
   assign overflow = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_buffer.sv
// Directed self-checking bench for reg_write_buffer.
module tb_reg_write_buffer;

   localparam int WIDTH = 12;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             inValid = 1'b0;
   logic [WIDTH-1:0] inData = '0;
   logic             inReady;
   logic             hold = 1'b0;
   logic             wrEn;
   logic [WIDTH-1:0] dataOut;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             overflow;

   int errors = 0;
   int checks = 0;

`ifdef REG_WRITE_BUFFER_OVERFLOW_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   reg_write_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inData(inData),
      .inReady(inReady), .hold(hold), .wrEn(wrEn), .dataOut(dataOut),
      .count(count), .full(full), .empty(empty), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // upstream must keep inData stable while a request is refused
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   always @(posedge clk) begin
      if (!rst && prev_stall && inValid) begin
         checks++;
         if (inData !== prev_data) begin
            errors++;
            $display("FAIL stable_data got=%h exp=%h", inData, prev_data);
         end
      end
      prev_stall = inValid && !inReady;
      prev_data  = inData;
   end

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; inValid = 1'b0; hold = 1'b0;
      for (int i = 0; i < 2; i++) begin
         edge_wait();
         checks++;
         if ({wrEn, dataOut, count, empty, full, inReady, overflow} !==
             {1'b0, 12'h000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got wrEn=%b d=%h cnt=%0d e=%b f=%b rdy=%b ovf=%b",
                     i, wrEn, dataOut, count, empty, full, inReady, overflow);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         edge_wait();
         checks++;
         if ({wrEn, dataOut, count, empty, inReady} !==
             {1'b0, 12'h000, 3'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got wrEn=%b d=%h cnt=%0d e=%b rdy=%b",
                     i, wrEn, dataOut, count, empty, inReady);
         end
      end
   endtask

   task automatic test_single_write();
      @(negedge clk);
      inValid = 1'b1; inData = 12'h014;
      edge_wait();
      checks++;
      if ({wrEn, count} !== {1'b0, 3'd1}) begin
         errors++;
         $display("FAIL single_push got wrEn=%b cnt=%0d exp wrEn=0 cnt=1", wrEn, count);
      end
      @(negedge clk);
      inValid = 1'b0;
      edge_wait();
      checks++;
      if ({wrEn, dataOut, count} !== {1'b1, 12'h014, 3'd0}) begin
         errors++;
         $display("FAIL single_pop got wrEn=%b d=%h cnt=%0d exp 1 014 0", wrEn, dataOut, count);
      end
      edge_wait();
      checks++;
      if ({wrEn, dataOut} !== {1'b0, 12'h014}) begin
         errors++;
         $display("FAIL single_after got wrEn=%b d=%h exp 0 014", wrEn, dataOut);
      end
   endtask

   task automatic test_burst_hold();
      logic [WIDTH-1:0] vals [4];
      vals[0] = 12'h02B; vals[1] = 12'h111; vals[2] = 12'h222; vals[3] = 12'h333;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         hold = 1'b1; inValid = 1'b1; inData = vals[i];
         edge_wait();
         checks++;
         if ({wrEn, count} !== {1'b0, 3'(i + 1)}) begin
            errors++;
            $display("FAIL burst_fill i=%0d got wrEn=%b cnt=%0d exp 0 %0d", i, wrEn, count, i + 1);
         end
      end
      checks++;
      if ({full, inReady, empty} !== 3'b100) begin
         errors++;
         $display("FAIL burst_full got f=%b rdy=%b e=%b exp 1 0 0", full, inReady, empty);
      end
      @(negedge clk);
      inData = 12'h444;
      edge_wait();
      checks++;
      if ({count, full, overflow} !== {3'd4, 1'b1, OVF_EXP}) begin
         errors++;
         $display("FAIL burst_refuse got cnt=%0d f=%b ovf=%b exp 4 1 %b", count, full, overflow, OVF_EXP);
      end
      @(negedge clk);
      inValid = 1'b0; hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         edge_wait();
         checks++;
         if ({wrEn, dataOut, count} !== {1'b1, vals[i], 3'(3 - i)}) begin
            errors++;
            $display("FAIL burst_drain i=%0d got wrEn=%b d=%h cnt=%0d exp 1 %h %0d",
                     i, wrEn, dataOut, count, vals[i], 3 - i);
         end
      end
      edge_wait();
      checks++;
      if ({wrEn, empty, overflow} !== {1'b0, 1'b1, OVF_EXP}) begin
         errors++;
         $display("FAIL burst_done got wrEn=%b e=%b ovf=%b exp 0 1 %b", wrEn, empty, overflow, OVF_EXP);
      end
   endtask

   task automatic test_streaming();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         hold = 1'b0; inValid = 1'b1; inData = 12'(k);
         edge_wait();
         checks++;
         if (k == 1) begin
            if ({wrEn, count} !== {1'b0, 3'd1}) begin
               errors++;
               $display("FAIL stream_first got wrEn=%b cnt=%0d exp 0 1", wrEn, count);
            end
         end else if ({wrEn, dataOut, count} !== {1'b1, 12'(k - 1), 3'd1}) begin
            errors++;
            $display("FAIL stream k=%0d got wrEn=%b d=%h cnt=%0d exp 1 %h 1",
                     k, wrEn, dataOut, count, k - 1);
         end
      end
      @(negedge clk);
      inValid = 1'b0;
      edge_wait();
      checks++;
      if ({wrEn, dataOut, count} !== {1'b1, 12'h00A, 3'd0}) begin
         errors++;
         $display("FAIL stream_last got wrEn=%b d=%h cnt=%0d exp 1 00a 0", wrEn, dataOut, count);
      end
      edge_wait();
      checks++;
      if (wrEn !== 1'b0) begin
         errors++;
         $display("FAIL stream_end got wrEn=%b exp 0", wrEn);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         hold = 1'b1; inValid = 1'b1; inData = 12'h0A5 + 12'(i);
         edge_wait();
      end
      @(negedge clk);
      inValid = 1'b0; hold = 1'b0;
      edge_wait();
      checks++;
      if ({wrEn, dataOut, count} !== {1'b1, 12'h0A5, 3'd2}) begin
         errors++;
         $display("FAIL mid_pre got wrEn=%b d=%h cnt=%0d exp 1 0a5 2", wrEn, dataOut, count);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({wrEn, dataOut, count, empty, overflow} !== {1'b0, 12'h000, 3'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mid_async got wrEn=%b d=%h cnt=%0d e=%b ovf=%b exp 0 000 0 1 0",
                  wrEn, dataOut, count, empty, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         edge_wait();
         checks++;
         if ({wrEn, count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL mid_after cyc=%0d got wrEn=%b cnt=%0d exp 0 0", i, wrEn, count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst_hold();
      test_streaming();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
